conv_24to32: RTL and testbench

Stream width converter sitting directly downstream of the 8→24 converter. It packs a stream of 24-bit words into 32-bit words, big-endian, with no added latency. Four input words produce three output words. Both sides use valid/ready handshakes. The 32-bit side feeds the FIFO/host-interface stages.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_24to32.sv | 93 +++++++++
 tb/tb_conv_24to32.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 24-to-32 bit stream packer.
package conv_pkg;

    localparam int W_IN  = 24;
    localparam int W_OUT = 32;

    typedef enum logic [1:0] {
        ST_R0 = 2'd0,
        ST_R3 = 2'd1,
        ST_R2 = 2'd2,
        ST_R1 = 2'd3
    } conv24to32_state_t;

    // Residue bytes left-aligned in a 32-bit word, zero-padded on the right.
    function automatic logic [W_OUT-1:0] pad_residue(conv24to32_state_t st,
                                                     logic [W_IN-1:0] res);
        logic [W_OUT-1:0] word;
        word = '0;
        case (st)
            ST_R3:   word = {res[23:0], 8'h00};
            ST_R2:   word = {res[23:8], 16'h0000};
            ST_R1:   word = {res[23:16], 24'h000000};
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/conv_24to32.sv
// Zero-latency big-endian packer: four 24-bit words in, three 32-bit words out.
// Optional flush of a partial group when CONV_24TO32_FLUSH_EN is defined.
//
// state | meaning
// ST_R0 | no residue; next word is absorbed without producing output
// ST_R3 | 3 residue bytes in res[23:0]
// ST_R2 | 2 residue bytes in res[23:8]
// ST_R1 | 1 residue byte in res[23:16]
module conv_24to32
    import conv_pkg::*;
(
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [W_IN-1:0]  data24_in,
    input  logic             valid24_in,
    output logic             ready24_out,
    output logic [W_OUT-1:0] data32_out,
    output logic             valid32_out,
`ifdef CONV_24TO32_FLUSH_EN
    input  logic             flush_in,
`endif
    input  logic             ready32_in
);

    conv24to32_state_t st_q, st_d;
    logic [W_IN-1:0]   res_q, res_d;
    logic              xfer;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            st_q  <= ST_R0;
            res_q <= '0;
        end else begin
            st_q  <= st_d;
            res_q <= res_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        res_d       = res_q;
        valid32_out = 1'b0;
        ready24_out = 1'b1;
        data32_out  = '0;
        xfer        = valid24_in && ready32_in;

        case (st_q)
            ST_R0: begin
                if (valid24_in) begin
                    res_d = data24_in;
                    st_d  = ST_R3;
                end
            end
            ST_R3: begin
                valid32_out = valid24_in;
                ready24_out = ready32_in;
                if (valid24_in) data32_out = {res_q[23:0], data24_in[23:16]};
                if (xfer) begin
                    res_d[23:8] = data24_in[15:0];
                    st_d        = ST_R2;
                end
            end
            ST_R2: begin
                valid32_out = valid24_in;
                ready24_out = ready32_in;
                if (valid24_in) data32_out = {res_q[23:8], data24_in[23:8]};
                if (xfer) begin
                    res_d[23:16] = data24_in[7:0];
                    st_d         = ST_R1;
                end
            end
            ST_R1: begin
                valid32_out = valid24_in;
                ready24_out = ready32_in;
                if (valid24_in) data32_out = {res_q[23:16], data24_in};
                if (xfer) st_d = ST_R0;
            end
            default: st_d = ST_R0;
        endcase

`ifdef CONV_24TO32_FLUSH_EN
        // Flush overrides any pending input; the input word stays unaccepted.
        if (flush_in && (st_q != ST_R0)) begin
            valid32_out = 1'b1;
            ready24_out = 1'b0;
            data32_out  = pad_residue(st_q, res_q);
            res_d       = res_q;
            st_d        = ready32_in ? ST_R0 : st_q;
        end
`endif
    end

endmodule

// File: tb/tb_conv_24to32.sv
// Scoreboard bench for conv_24to32: byte-queue reference model, randomized stream.
module tb_conv_24to32;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [23:0] data24_in = '0;
    logic        valid24_in = 1'b0;
    logic        ready24_out;
    logic [31:0] data32_out;
    logic        valid32_out;
    logic        ready32_in = 1'b0;
`ifdef CONV_24TO32_FLUSH_EN
    logic        flush_in = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  bq[$];      // residue bytes in stream order
    logic [31:0] exp_q[$];   // words the DUT is expected to present

    always #5 clk_in = ~clk_in;

    conv_24to32 dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .data24_in   (data24_in),
        .valid24_in  (valid24_in),
        .ready24_out (ready24_out),
        .data32_out  (data32_out),
        .valid32_out (valid32_out),
`ifdef CONV_24TO32_FLUSH_EN
        .flush_in    (flush_in),
`endif
        .ready32_in  (ready32_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT presents a word, it must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk_in);
            if (valid32_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", data32_out, 32'hxxxxxxxx);
                end else begin
                    chk("data32", data32_out, exp_q.pop_front());
                end
            end else begin
                chk("data32_idle_zero", data32_out, 32'h0);
            end
        end
    end

    // One cycle of stimulus; the model predicts handshake behaviour at byte level.
    task automatic step(input logic v, input logic [23:0] d, input logic r, input logic f);
        logic        fl;
        logic        exp_v, exp_r;
        logic [31:0] word;
        logic [7:0]  tmp[$];
        int          held;
        @(posedge clk_in);
        #1;
        valid24_in = v;
        data24_in  = d;
        ready32_in = r;
`ifdef CONV_24TO32_FLUSH_EN
        flush_in   = f;
        fl         = f;
`else
        fl         = 1'b0;
`endif
        #1;
        held  = bq.size();
        exp_v = 1'b0;
        exp_r = 1'b1;
        word  = '0;
        if (fl && held > 0) begin
            exp_v = 1'b1;
            exp_r = 1'b0;
            for (int i = 0; i < held; i++) word[31-8*i -: 8] = bq[i];
            if (r) bq.delete();
        end else if (held == 0) begin
            if (v) begin
                bq.push_back(d[23:16]);
                bq.push_back(d[15:8]);
                bq.push_back(d[7:0]);
            end
        end else begin
            exp_r = r;
            exp_v = v;
            if (v) begin
                tmp = bq;
                tmp.push_back(d[23:16]);
                tmp.push_back(d[15:8]);
                tmp.push_back(d[7:0]);
                word = {tmp[0], tmp[1], tmp[2], tmp[3]};
                if (r) begin
                    repeat (4) void'(tmp.pop_front());
                    bq = tmp;
                end
            end
        end
        chk("ready24", {31'b0, ready24_out}, {31'b0, exp_r});
        chk("valid32", {31'b0, valid32_out}, {31'b0, exp_v});
        if (exp_v) exp_q.push_back(word);
    endtask

    task automatic pulse_reset();
        @(posedge clk_in);
        #1;
        valid24_in = 1'b0;
        ready32_in = 1'b0;
`ifdef CONV_24TO32_FLUSH_EN
        flush_in   = 1'b0;
`endif
        #1;
        reset_in = 1'b0;
        #1;
        chk("rst_valid32", {31'b0, valid32_out}, 32'd0);
        chk("rst_ready24", {31'b0, ready24_out}, 32'd1);
        chk("rst_data32", data32_out, 32'h0);
        #1;
        reset_in = 1'b1;
        bq.delete();
    endtask

    logic [23:0] steady[4];

    initial begin
        steady[0] = 24'h123456;
        steady[1] = 24'h789ABC;
        steady[2] = 24'hDEF012;
        steady[3] = 24'h345678;

        #3;
        chk("init_valid32", {31'b0, valid32_out}, 32'd0);
        chk("init_ready24", {31'b0, ready24_out}, 32'd1);
        chk("init_data32", data32_out, 32'h0);
        #9;
        reset_in = 1'b1;

        // Steady stream: expect 12345678, 9ABCDEF0, 12345678.
        for (int i = 0; i < 4; i++) step(1'b1, steady[i], 1'b1, 1'b0);

        // Backpressure while holding the second word.
        step(1'b1, 24'h123456, 1'b1, 1'b0);
        repeat (3) step(1'b1, 24'h789ABC, 1'b0, 1'b0);
        step(1'b1, 24'h789ABC, 1'b1, 1'b0);
        step(1'b1, 24'hDEF012, 1'b1, 1'b0);
        step(1'b1, 24'h345678, 1'b1, 1'b0);

        // Input stall with two residue bytes held.
        step(1'b1, 24'h123456, 1'b1, 1'b0);
        step(1'b1, 24'h789ABC, 1'b1, 1'b0);
        step(1'b0, 24'hFFFFFF, 1'b1, 1'b0);
        step(1'b0, 24'hFFFFFF, 1'b0, 1'b0);
        step(1'b1, 24'hDEF012, 1'b1, 1'b0);
        step(1'b1, 24'h345678, 1'b1, 1'b0);

        // Empty state accepts regardless of downstream readiness.
        step(1'b1, 24'hAABBCC, 1'b0, 1'b0);
        step(1'b1, 24'hDDEEFF, 1'b1, 1'b0);
        step(1'b1, 24'h001122, 1'b1, 1'b0);
        step(1'b1, 24'h334455, 1'b1, 1'b0);

        // Reset mid-group discards the residue.
        step(1'b1, 24'h123456, 1'b1, 1'b0);
        step(1'b1, 24'h789ABC, 1'b1, 1'b0);
        pulse_reset();
        step(1'b1, 24'h111111, 1'b1, 1'b0);
        step(1'b1, 24'h222222, 1'b1, 1'b0);
        step(1'b1, 24'h333333, 1'b1, 1'b0);
        step(1'b1, 24'h444444, 1'b1, 1'b0);

`ifdef CONV_24TO32_FLUSH_EN
        step(1'b1, 24'h123456, 1'b1, 1'b0);
        step(1'b1, 24'h789ABC, 1'b1, 1'b0);
        step(1'b1, 24'hDEF012, 1'b0, 1'b1);
        step(1'b1, 24'hDEF012, 1'b1, 1'b1);
        step(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        step(1'b0, 24'h000000, 1'b1, 1'b1);
        step(1'b0, 24'h000000, 1'b1, 1'b0);
        step(1'b0, 24'h000000, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0);
            if (i == 300) pulse_reset();
        end

        step(1'b0, 24'h000000, 1'b1, 1'b0);
        @(posedge clk_in);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
